// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I main-control decode: opcodes, write-back/ALU selectors
// and the per-lane control bundle.
package ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [1:0] {WbAlu, WbMem, WbPc4, WbImm} wb_sel_e;
  typedef enum logic [1:0] {AluAdd, AluCmp, AluFunct} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    alu_src;
    logic    branch;
    logic    jump;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    wb_sel_e wb_sel;
    alu_op_e alu_op;
    logic    rs1_used;
    logic    rs2_used;
  } ctrl_t;

  localparam int unsigned CtrlW = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_opcode_dec.sv
// Combinational opcode decoder: one 32-bit instruction in, control bundle plus
// illegal flag out. Unknown opcodes produce an all-zero bundle.
module ctrl_opcode_dec
  import ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  ctrl_t c;

  // Only the opcode drives control; operand fields are read by the hazard check.
  logic unused_fields;
  assign unused_fields = ^instr_i[31:7];

  always_comb begin
    c         = '0;
    illegal_o = 1'b0;
    unique case (instr_i[6:0])
      OpR: begin
        c.reg_write = 1'b1;
        c.alu_op    = AluFunct;
        c.rs1_used  = 1'b1;
        c.rs2_used  = 1'b1;
      end
      OpImm: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = AluFunct;
        c.rs1_used  = 1'b1;
      end
      OpLoad: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.mem_read  = 1'b1;
        c.wb_sel    = WbMem;
        c.rs1_used  = 1'b1;
      end
      OpStore: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.rs1_used  = 1'b1;
        c.rs2_used  = 1'b1;
      end
      OpBranch: begin
        c.branch   = 1'b1;
        c.alu_op   = AluCmp;
        c.rs1_used = 1'b1;
        c.rs2_used = 1'b1;
      end
      OpJal: begin
        c.reg_write = 1'b1;
        c.jump      = 1'b1;
        c.wb_sel    = WbPc4;
      end
      OpJalr: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.jump      = 1'b1;
        c.wb_sel    = WbPc4;
        c.rs1_used  = 1'b1;
      end
      OpLui: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WbImm;
      end
      OpAuipc: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    c.mem_to_reg = (c.wb_sel == WbMem);
  end

  assign ctrl_o = c;

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered main-control decode stage for 1 or 2 lanes with valid/ready, flush,
// dependency-driven bundle split and a saturating illegal-lane counter.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [32*LANES-1:0]      in_instr_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LANES-1:0]         out_lane_valid_o,
  output logic [CtrlW*LANES-1:0]   out_ctrl_o,
  output logic [LANES-1:0]         out_illegal_o,
  output logic [CNT_W-1:0]         illegal_count_o
);

  typedef enum logic {StNormal, StSplit} state_e;

  localparam logic [LANES-1:0] Lane0    = LANES'(1);
  localparam logic [LANES-1:0] LaneLast = Lane0 << (LANES - 1);

  ctrl_t [LANES-1:0] dec_ctrl;
  logic  [LANES-1:0] dec_ill;
  logic              split;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ctrl_opcode_dec u_dec (
      .instr_i  (in_instr_i[32*k +: 32]),
      .ctrl_o   (dec_ctrl[k]),
      .illegal_o(dec_ill[k])
    );
  end

  if (LANES == 2) begin : g_split
    logic [4:0] rd0, rs1_1, rs2_1;
    logic       raw;
    assign rd0   = in_instr_i[11:7];
    assign rs1_1 = in_instr_i[32*(LANES-1)+15 +: 5];
    assign rs2_1 = in_instr_i[32*(LANES-1)+20 +: 5];
    assign raw   = dec_ctrl[0].reg_write && (rd0 != 5'd0) &&
                   ((dec_ctrl[LANES-1].rs1_used && (rs1_1 == rd0)) ||
                    (dec_ctrl[LANES-1].rs2_used && (rs2_1 == rd0)));
    // Control flow in lane0 also splits so lane1 never issues alongside a redirect.
    assign split = raw || dec_ctrl[0].branch || dec_ctrl[0].jump;
  end else if (LANES == 1) begin : g_single
    assign split = 1'b0;
  end else begin : g_bad_lanes
    $error("ctrl_decode_stage: LANES must be 1 or 2");
  end

  state_e            state_q;
  logic              out_valid_q;
  logic [LANES-1:0]  lv_q, ill_q;
  ctrl_t [LANES-1:0] ctrl_q;
  ctrl_t             pend_ctrl_q;
  logic              pend_ill_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_hs, out_free, in_hs;
  logic [1:0]        n_ill;
  logic [CNT_W+1:0]  cnt_sum;
  ctrl_t [LANES-1:0] head_ctrl, tail_ctrl;
  logic  [LANES-1:0] head_ill, tail_ill;

  assign out_hs     = out_valid_q && out_ready_i;
  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = !flush_i && (state_q == StNormal) && out_free;
  assign in_hs      = in_valid_i && in_ready_o;

  always_comb begin
    n_ill = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      n_ill = n_ill + 2'(ill_q[i] & lv_q[i]);
    end
    cnt_sum = {2'b00, cnt_q} + (CNT_W + 2)'(n_ill);
    cnt_d   = (cnt_sum[CNT_W+1:CNT_W] != 2'b00) ? '1 : cnt_sum[CNT_W-1:0];

    head_ctrl          = '0;
    head_ctrl[0]       = dec_ctrl[0];
    head_ill           = '0;
    head_ill[0]        = dec_ill[0];
    tail_ctrl          = '0;
    tail_ctrl[LANES-1] = pend_ctrl_q;
    tail_ill           = '0;
    tail_ill[LANES-1]  = pend_ill_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StNormal;
      out_valid_q <= 1'b0;
      lv_q        <= '0;
      ctrl_q      <= '0;
      ill_q       <= '0;
      pend_ctrl_q <= '0;
      pend_ill_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (out_hs) cnt_q <= cnt_d;
      if (flush_i) begin
        state_q     <= StNormal;
        out_valid_q <= 1'b0;
        lv_q        <= '0;
        ctrl_q      <= '0;
        ill_q       <= '0;
        pend_ctrl_q <= '0;
        pend_ill_q  <= 1'b0;
      end else if (out_free) begin
        unique case (state_q)
          StNormal: begin
            if (in_hs) begin
              out_valid_q <= 1'b1;
              if (split) begin
                lv_q        <= Lane0;
                ctrl_q      <= head_ctrl;
                ill_q       <= head_ill;
                pend_ctrl_q <= dec_ctrl[LANES-1];
                pend_ill_q  <= dec_ill[LANES-1];
                state_q     <= StSplit;
              end else begin
                lv_q   <= '1;
                ctrl_q <= dec_ctrl;
                ill_q  <= dec_ill;
              end
            end else begin
              out_valid_q <= 1'b0;
              lv_q        <= '0;
              ctrl_q      <= '0;
              ill_q       <= '0;
            end
          end
          StSplit: begin
            out_valid_q <= 1'b1;
            lv_q        <= LaneLast;
            ctrl_q      <= tail_ctrl;
            ill_q       <= tail_ill;
            state_q     <= StNormal;
          end
          default: state_q <= StNormal;
        endcase
      end
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_lane_valid_o = lv_q;
  assign out_ctrl_o       = ctrl_q;
  assign out_illegal_o    = ill_q;
  assign illegal_count_o  = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: directed scenarios then random traffic, all checked against
// a queue-of-expected-bundles model built from the opcode table and the split rule.
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_instr = '0;
  logic        in_ready, out_valid;
  logic [1:0]  out_lane_valid, out_illegal, illegal_count;
  logic [25:0] out_ctrl;

  ctrl_decode_stage #(.LANES(2), .CNT_W(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_instr_i      (in_instr),
    .flush_i         (flush),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_lane_valid_o(out_lane_valid),
    .out_ctrl_o      (out_ctrl),
    .out_illegal_o   (out_illegal),
    .illegal_count_o (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       lv;
    logic [1:0][12:0] ctrl;
    logic [1:0]       ill;
  } bundle_t;

  bundle_t    q[$];
  logic [1:0] m_cnt = 2'd0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // {illegal, reg_write, alu_src, branch, jump, mem_read, mem_write, mem_to_reg,
  //  wb_sel(ALU=0,MEM=1,PC4=2,IMM=3), alu_op(ADD=0,CMP=1,FUNCT=2), rs1_used, rs2_used}
  function automatic logic [13:0] ref_dec(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return 14'b0_1000000_00_10_11;
      7'b0010011: return 14'b0_1100000_00_10_10;
      7'b0000011: return 14'b0_1100101_01_00_10;
      7'b0100011: return 14'b0_0100010_00_00_11;
      7'b1100011: return 14'b0_0010000_00_01_11;
      7'b1101111: return 14'b0_1001000_10_00_00;
      7'b1100111: return 14'b0_1101000_10_00_10;
      7'b0110111: return 14'b0_1000000_11_00_00;
      7'b0010111: return 14'b0_1100000_00_00_00;
      default:    return 14'b1_0000000_00_00_00;
    endcase
  endfunction

  function automatic logic must_split(input logic [31:0] i0, input logic [31:0] i1);
    logic [13:0] d0, d1;
    logic [4:0]  rd0;
    logic        uses;
    d0   = ref_dec(i0);
    d1   = ref_dec(i1);
    rd0  = i0[11:7];
    uses = (d1[1] && i1[19:15] == rd0) || (d1[0] && i1[24:20] == rd0);
    return (d0[12] && rd0 != 5'd0 && uses) || d0[10] || d0[9];
  endfunction

  function automatic logic exp_ready();
    return !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
  endfunction

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("lane_valid", 64'(out_lane_valid), 64'(q[0].lv));
      for (int l = 0; l < 2; l++) begin
        if (q[0].lv[l]) begin
          chk($sformatf("ctrl_lane%0d", l), 64'(out_ctrl[13*l +: 13]), 64'(q[0].ctrl[l]));
          chk($sformatf("illegal_lane%0d", l), 64'(out_illegal[l]), 64'(q[0].ill[l]));
        end
      end
    end
    chk("in_ready", 64'(in_ready), 64'(exp_ready()));
    chk("illegal_count", 64'(illegal_count), 64'(m_cnt));
  endtask

  task automatic model_edge(input logic rdy);
    bundle_t     b;
    logic [13:0] d0, d1;
    int          tot;
    if (q.size() != 0 && out_ready) begin
      tot = int'(m_cnt) + int'(q[0].ill[0] & q[0].lv[0]) + int'(q[0].ill[1] & q[0].lv[1]);
      m_cnt = (tot > 3) ? 2'd3 : 2'(tot);
      void'(q.pop_front());
    end
    if (flush) begin
      q.delete();
    end else if (in_valid && rdy) begin
      d0 = ref_dec(in_instr[31:0]);
      d1 = ref_dec(in_instr[63:32]);
      if (must_split(in_instr[31:0], in_instr[63:32])) begin
        b = '0; b.lv = 2'b01; b.ctrl[0] = d0[12:0]; b.ill[0] = d0[13];
        q.push_back(b);
        b = '0; b.lv = 2'b10; b.ctrl[1] = d1[12:0]; b.ill[1] = d1[13];
        q.push_back(b);
      end else begin
        b.lv = 2'b11; b.ctrl[0] = d0[12:0]; b.ctrl[1] = d1[12:0];
        b.ill = {d1[13], d0[13]};
        q.push_back(b);
      end
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    logic rdy;
    #1;
    check_outputs();
    rdy = exp_ready();
    @(posedge clk);
    model_edge(rdy);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 2'd0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(illegal_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [0:8];
    logic [31:0] ins;
    int          sel;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    sel = $urandom_range(0, 10);
    ins = $urandom;
    ins[6:0]   = (sel < 9) ? ops[sel] : 7'($urandom);
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  localparam logic [31:0] AddX2  = 32'h00108133;
  localparam logic [31:0] AddiX1 = 32'h00500093;
  localparam logic [31:0] LwX3   = 32'h00002183;
  localparam logic [31:0] SwX3   = 32'h00302223;
  localparam logic [31:0] Nop    = 32'h00000013;

  initial begin
    int cnt_seq [5];
    cnt_seq = '{1, 2, 3, 3, 3};

    #1 rst = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_lane_valid", 64'(out_lane_valid), 64'd0);
    chk("reset_ctrl", 64'(out_ctrl), 64'd0);
    chk("reset_illegal", 64'(out_illegal), 64'd0);
    chk("reset_count", 64'(illegal_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // RAW dependency on x1 splits the bundle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = {AddX2, AddiX1};
    step();
    in_valid = 1'b0;
    #1;
    chk("t1_first_lv", 64'(out_lane_valid), 64'(2'b01));
    chk("t1_split_ready", 64'(in_ready), 64'd0);
    step();
    #1;
    chk("t1_second_lv", 64'(out_lane_valid), 64'(2'b10));
    chk("t1_ready_back", 64'(in_ready), 64'd1);
    step();

    // Independent load in lane1.
    in_valid = 1'b1;
    in_instr = {LwX3, AddiX1};
    step();
    in_valid = 1'b0;
    #1;
    chk("t2_lv", 64'(out_lane_valid), 64'(2'b11));
    chk("t2_lane1_ctrl", 64'(out_ctrl[25:13]), 64'(13'b1100101_01_00_10));
    step();

    // Illegal lane0 beside a store.
    in_valid = 1'b1;
    in_instr = {SwX3, 32'h0};
    step();
    in_valid = 1'b0;
    #1;
    chk("t3_illegal", 64'(out_illegal), 64'(2'b01));
    chk("t3_lane0_ctrl", 64'(out_ctrl[12:0]), 64'd0);
    chk("t3_lane1_mem_write", 64'(out_ctrl[20]), 64'd1);
    chk("t3_count_before", 64'(illegal_count), 64'd0);
    step();
    #1;
    chk("t3_count_after", 64'(illegal_count), 64'd1);

    // Backpressure: output held for 5 cycles, next bundle taken when ready returns.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = {SwX3, AddiX1};
    step();
    in_instr = {LwX3, Nop};
    repeat (5) begin
      #1;
      chk("t4_stall_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_ready_return", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    step();
    step();

    // Flush while the split's lane0 half is on the output.
    in_valid = 1'b1;
    in_instr = {AddX2, AddiX1};
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("t5_flushed_valid", 64'(out_valid), 64'd0);
    chk("t5_flushed_ready", 64'(in_ready), 64'd1);
    repeat (3) step();

    // Counter saturation at CNT_W=2.
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_instr = {Nop, 32'h0};
      step();
      in_valid = 1'b0;
      step();
      #1;
      chk($sformatf("t6_count_%0d", k), 64'(illegal_count), 64'(cnt_seq[k]));
    end

    // Asynchronous reset while a split is pending.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = {AddX2, AddiX1};
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 2'd0;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_lv", 64'(out_lane_valid), 64'd0);
    chk("t6_rst_ctrl", 64'(out_ctrl), 64'd0);
    chk("t6_rst_illegal", 64'(out_illegal), 64'd0);
    chk("t6_rst_count", 64'(illegal_count), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // Random traffic.
    repeat (3000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = {rand_instr(), rand_instr()};
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
